// File: rtl/calc_key_seq.sv
// calc_key_seq: key sequencer for a four-function calculator front end.
//
// This block turns a stream of keypad codes into one-cycle control strobes
// for an operand entry register and an ALU. It also tracks which operand is
// being entered and which operator is pending.
//
// Parameters:
//   DIGITS - maximum decimal digits accepted per operand (1..15)
//   CW     - digit counter width, with 2**CW > DIGITS
//
// Ports:
//   clk      in   single clock, rising edge
//   rst_n    in   synchronous active-low reset
//   key_vld  in   one-cycle strobe qualifying key
//   key[3:0] in   0-9 digit, A clear, B minus, C plus, D equals, E getM, F setM
//   alu_done in   one-cycle ALU completion strobe
//   key_rdy  out  high when a key presented this cycle is accepted
//   dig_ld   out  load dig into the entry register (strobe)
//   dig[3:0] out  last loaded digit (level)
//   ent_clr  out  clear the entry register (strobe)
//   all_clr  out  clear everything (strobe)
//   op_sub   out  latched operator, 1 = subtract (level)
//   alu_go   out  start the ALU (strobe)
//   mem_rd   out  recall memory into the entry register (strobe)
//   mem_wr   out  store the entry register to memory (strobe)
//   dig_ovf  out  digit rejected because the operand is full (strobe)
//   st[2:0]  out  current state code for the display
//
// Optional feature: define CALC_MEM_EN to enable the E (getM) and F (setM)
// memory keys. Without it, E and F are ignored and mem_rd/mem_wr are tied low.

module calc_key_seq #(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned CW     = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_vld,
  input  logic [3:0] key,
  input  logic       alu_done,
  output logic       key_rdy,
  output logic       dig_ld,
  output logic [3:0] dig,
  output logic       ent_clr,
  output logic       all_clr,
  output logic       op_sub,
  output logic       alu_go,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       dig_ovf,
  output logic [2:0] st
);

  localparam logic [2:0] S_A1   = 3'd0;
  localparam logic [2:0] S_N1   = 3'd1;
  localparam logic [2:0] S_OP   = 3'd2;
  localparam logic [2:0] S_N2   = 3'd3;
  localparam logic [2:0] S_RES  = 3'd4;
  localparam logic [2:0] S_WAIT = 3'd5;

  localparam logic [3:0] K_CLR  = 4'hA;
  localparam logic [3:0] K_SUB  = 4'hB;
  localparam logic [3:0] K_ADD  = 4'hC;
  localparam logic [3:0] K_EQ   = 4'hD;
`ifdef CALC_MEM_EN
  localparam logic [3:0] K_GETM = 4'hE;
  localparam logic [3:0] K_SETM = 4'hF;
`endif

  localparam logic [CW-1:0] CNT_MAX = CW'(DIGITS);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [2:0]    state, n_state;
  logic [2:0]    ret_st, n_ret_st;
  logic [CW-1:0] count, n_count;
  logic          op_r, n_op;
  logic          pend_op, n_pend_op;
  logic [3:0]    dig_r, n_dig;
  logic          n_dig_ld, n_ent_clr, n_all_clr, n_alu_go, n_dig_ovf;
  logic          n_mem_rd, n_mem_wr;
  logic          accept, is_digit;

`ifdef CALC_MEM_EN
  logic          mem_vld, n_mem_vld;
`endif

  assign key_rdy  = (state != S_WAIT);
  assign accept   = key_vld && key_rdy;
  assign is_digit = (key <= 4'd9);
  assign st       = state;
  assign op_sub   = op_r;
  assign dig      = dig_r;

  always_comb begin
    n_state   = state;
    n_ret_st  = ret_st;
    n_count   = count;
    n_op      = op_r;
    n_pend_op = pend_op;
    n_dig     = dig_r;
    n_dig_ld  = 1'b0;
    n_ent_clr = 1'b0;
    n_all_clr = 1'b0;
    n_alu_go  = 1'b0;
    n_dig_ovf = 1'b0;
    n_mem_rd  = 1'b0;
    n_mem_wr  = 1'b0;
`ifdef CALC_MEM_EN
    n_mem_vld = mem_vld;
`endif

    if (state == S_WAIT) begin
      // The operator keyed while chaining is held back until the ALU has
      // finished, so op_sub stays stable for the whole operation.
      if (alu_done) begin
        n_state = ret_st;
        n_op    = pend_op;
      end
    end else if (accept) begin
      if (key == K_CLR) begin
        n_all_clr = 1'b1;
        n_count   = '0;
        n_state   = S_A1;
      end else if (is_digit) begin
        case (state)
          S_A1, S_RES, S_OP: begin
            n_ent_clr = 1'b1;
            n_dig_ld  = 1'b1;
            n_dig     = key;
            n_count   = CNT_ONE;
            n_state   = (state == S_OP) ? S_N2 : S_N1;
          end
          S_N1, S_N2: begin
            if (count < CNT_MAX) begin
              n_dig_ld = 1'b1;
              n_dig    = key;
              n_count  = count + CNT_ONE;
            end else begin
              n_dig_ovf = 1'b1;
            end
          end
          default: ;
        endcase
      end else begin
        case (key)
          K_SUB, K_ADD: begin
            case (state)
              S_N1, S_RES, S_OP: begin
                n_op    = (key == K_SUB);
                n_state = S_OP;
              end
              S_N2: begin
                n_alu_go  = 1'b1;
                n_pend_op = (key == K_SUB);
                n_ret_st  = S_OP;
                n_state   = S_WAIT;
              end
              default: ;
            endcase
          end
          K_EQ: begin
            if (state == S_N2) begin
              n_alu_go  = 1'b1;
              n_pend_op = op_r;
              n_ret_st  = S_RES;
              n_state   = S_WAIT;
            end
          end
`ifdef CALC_MEM_EN
          K_SETM: begin
            if (state == S_N1 || state == S_RES) begin
              n_mem_wr  = 1'b1;
              n_mem_vld = 1'b1;
            end
          end
          K_GETM: begin
            // A recalled value fills the operand, so further digits overflow.
            if (mem_vld) begin
              n_ent_clr = 1'b1;
              n_mem_rd  = 1'b1;
              n_count   = CNT_MAX;
              n_state   = (state == S_OP || state == S_N2) ? S_N2 : S_N1;
            end
          end
`endif
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_A1;
      ret_st  <= S_A1;
      count   <= '0;
      op_r    <= 1'b0;
      pend_op <= 1'b0;
      dig_r   <= '0;
      dig_ld  <= 1'b0;
      ent_clr <= 1'b0;
      all_clr <= 1'b0;
      alu_go  <= 1'b0;
      dig_ovf <= 1'b0;
    end else begin
      state   <= n_state;
      ret_st  <= n_ret_st;
      count   <= n_count;
      op_r    <= n_op;
      pend_op <= n_pend_op;
      dig_r   <= n_dig;
      dig_ld  <= n_dig_ld;
      ent_clr <= n_ent_clr;
      all_clr <= n_all_clr;
      alu_go  <= n_alu_go;
      dig_ovf <= n_dig_ovf;
    end
  end

`ifdef CALC_MEM_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_vld <= 1'b0;
      mem_rd  <= 1'b0;
      mem_wr  <= 1'b0;
    end else begin
      mem_vld <= n_mem_vld;
      mem_rd  <= n_mem_rd;
      mem_wr  <= n_mem_wr;
    end
  end
`else
  assign mem_rd = 1'b0;
  assign mem_wr = 1'b0;

  logic unused_mem;
  assign unused_mem = n_mem_rd | n_mem_wr;
`endif

endmodule

// File: tb/tb_calc_key_seq.sv
module tb_calc_key_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_vld = 1'b0;
  logic [3:0] key = 4'h0;
  logic       alu_done = 1'b0;
  logic       key_rdy, dig_ld, ent_clr, all_clr, op_sub, alu_go;
  logic       mem_rd, mem_wr, dig_ovf;
  logic [3:0] dig;
  logic [2:0] st;

  int checks = 0;
  int errors = 0;

`ifdef CALC_MEM_EN
  localparam bit MEM = 1'b1;
`else
  localparam bit MEM = 1'b0;
`endif

  calc_key_seq #(.DIGITS(4), .CW(3)) dut (
    .clk(clk), .rst_n(rst_n), .key_vld(key_vld), .key(key),
    .alu_done(alu_done), .key_rdy(key_rdy), .dig_ld(dig_ld), .dig(dig),
    .ent_clr(ent_clr), .all_clr(all_clr), .op_sub(op_sub), .alu_go(alu_go),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .dig_ovf(dig_ovf), .st(st)
  );

  always #5 clk = ~clk;

  // Running pulse counts; tests compare deltas.
  int n_dig_ld = 0, n_alu_go = 0, n_dig_ovf = 0, n_ent_clr = 0;
  int n_mem_rd = 0, n_mem_wr = 0, n_all_clr = 0;
  always @(negedge clk) begin
    if (dig_ld)  n_dig_ld++;
    if (alu_go)  n_alu_go++;
    if (dig_ovf) n_dig_ovf++;
    if (ent_clr) n_ent_clr++;
    if (mem_rd)  n_mem_rd++;
    if (mem_wr)  n_mem_wr++;
    if (all_clr) n_all_clr++;
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; key_vld = 1'b0; alu_done = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  // Present one key for one cycle; returns #1 after the negedge following
  // the accepting edge, while the resulting strobes are visible.
  task automatic press(input logic [3:0] k);
    @(negedge clk);
    key_vld = 1'b1; key = k;
    @(negedge clk);
    key_vld = 1'b0; key = 4'h0;
    #1;
  endtask

  task automatic pulse_done();
    @(negedge clk);
    alu_done = 1'b1;
    @(negedge clk);
    alu_done = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (st !== 3'd0) begin errors++; $display("FAIL reset_st: got %0d expected 0", st); end
    checks++; if (key_rdy !== 1'b1) begin errors++; $display("FAIL reset_key_rdy: got %b expected 1", key_rdy); end
    checks++; if ({dig_ld, ent_clr, all_clr, alu_go, mem_rd, mem_wr, dig_ovf} !== 7'b0) begin
      errors++; $display("FAIL reset_strobes: got %b expected 0000000", {dig_ld, ent_clr, all_clr, alu_go, mem_rd, mem_wr, dig_ovf}); end
    checks++; if (op_sub !== 1'b0) begin errors++; $display("FAIL reset_op_sub: got %b expected 0", op_sub); end
    checks++; if (dig !== 4'd0) begin errors++; $display("FAIL reset_dig: got %0d expected 0", dig); end
  endtask

  task automatic test_basic();
    int b_ld, b_go;
    do_reset();
    b_ld = n_dig_ld; b_go = n_alu_go;
    press(4'd1);
    checks++; if (st !== 3'd1) begin errors++; $display("FAIL basic_st1: got %0d expected 1", st); end
    checks++; if ({ent_clr, dig_ld} !== 2'b11) begin errors++; $display("FAIL basic_first_digit: got %b expected 11", {ent_clr, dig_ld}); end
    press(4'd2);
    checks++; if ({st, dig, ent_clr} !== {3'd1, 4'd2, 1'b0}) begin errors++; $display("FAIL basic_second_digit: st %0d dig %0d ent_clr %b expected 1 2 0", st, dig, ent_clr); end
    press(4'hC);
    checks++; if ({st, op_sub} !== {3'd2, 1'b0}) begin errors++; $display("FAIL basic_plus: st %0d op_sub %b expected 2 0", st, op_sub); end
    press(4'd3);
    checks++; if (st !== 3'd3) begin errors++; $display("FAIL basic_st3: got %0d expected 3", st); end
    press(4'hD);
    checks++; if ({st, alu_go, key_rdy} !== {3'd5, 1'b1, 1'b0}) begin errors++; $display("FAIL basic_equals: st %0d alu_go %b key_rdy %b expected 5 1 0", st, alu_go, key_rdy); end
    @(negedge clk);
    pulse_done();
    checks++; if (st !== 3'd4) begin errors++; $display("FAIL basic_result: got st %0d expected 4", st); end
    checks++; if (n_dig_ld - b_ld !== 3) begin errors++; $display("FAIL basic_dig_ld_count: got %0d expected 3", n_dig_ld - b_ld); end
    checks++; if (n_alu_go - b_go !== 1) begin errors++; $display("FAIL basic_alu_go_count: got %0d expected 1", n_alu_go - b_go); end
    pulse_done();
    checks++; if (st !== 3'd4) begin errors++; $display("FAIL basic_stray_done: got st %0d expected 4", st); end
  endtask

  task automatic test_overflow();
    int b_ld, b_ovf;
    do_reset();
    b_ld = n_dig_ld; b_ovf = n_dig_ovf;
    for (int i = 0; i < 6; i++) press(4'd9);
    checks++; if (n_dig_ld - b_ld !== 4) begin errors++; $display("FAIL ovf_dig_ld_count: got %0d expected 4", n_dig_ld - b_ld); end
    checks++; if (n_dig_ovf - b_ovf !== 2) begin errors++; $display("FAIL ovf_count: got %0d expected 2", n_dig_ovf - b_ovf); end
    checks++; if ({st, dig} !== {3'd1, 4'd9}) begin errors++; $display("FAIL ovf_state: st %0d dig %0d expected 1 9", st, dig); end
  endtask

  task automatic test_chain();
    int b_ld, b_clr;
    do_reset();
    press(4'd5);
    press(4'hB);
    checks++; if ({st, op_sub} !== {3'd2, 1'b1}) begin errors++; $display("FAIL chain_minus: st %0d op_sub %b expected 2 1", st, op_sub); end
    press(4'd4);
    press(4'hC);
    checks++; if ({st, alu_go, op_sub} !== {3'd5, 1'b1, 1'b1}) begin errors++; $display("FAIL chain_go: st %0d alu_go %b op_sub %b expected 5 1 1", st, alu_go, op_sub); end
    checks++; if (key_rdy !== 1'b0) begin errors++; $display("FAIL chain_wait_rdy: got %b expected 0", key_rdy); end
    b_ld = n_dig_ld;
    press(4'd7);
    checks++; if ({st, dig} !== {3'd5, 4'd4}) begin errors++; $display("FAIL chain_drop_key: st %0d dig %0d expected 5 4", st, dig); end
    checks++; if (n_dig_ld - b_ld !== 0) begin errors++; $display("FAIL chain_drop_dig_ld: got %0d expected 0", n_dig_ld - b_ld); end
    // alu_done together with a key: transition taken, key dropped.
    b_clr = n_ent_clr;
    @(negedge clk);
    alu_done = 1'b1; key_vld = 1'b1; key = 4'd8;
    @(negedge clk);
    alu_done = 1'b0; key_vld = 1'b0; key = 4'h0;
    #1;
    checks++; if ({st, op_sub} !== {3'd2, 1'b0}) begin errors++; $display("FAIL chain_return: st %0d op_sub %b expected 2 0", st, op_sub); end
    checks++; if ((n_dig_ld - b_ld) + (n_ent_clr - b_clr) !== 0) begin errors++; $display("FAIL chain_simul_key: got %0d strobes expected 0", (n_dig_ld - b_ld) + (n_ent_clr - b_clr)); end
  endtask

  task automatic test_clear();
    int b_go, b_ld;
    do_reset();
    press(4'd1);
    press(4'hB);
    press(4'd2);
    press(4'hA);
    checks++; if ({st, all_clr} !== {3'd0, 1'b1}) begin errors++; $display("FAIL clear_all: st %0d all_clr %b expected 0 1", st, all_clr); end
    checks++; if (op_sub !== 1'b1) begin errors++; $display("FAIL clear_keeps_op: got %b expected 1", op_sub); end
    b_go = n_alu_go; b_ld = n_dig_ld;
    press(4'hC);
    checks++; if ({st, op_sub, all_clr, ent_clr} !== {3'd0, 1'b1, 1'b0, 1'b0}) begin errors++; $display("FAIL clear_then_plus: st %0d op_sub %b all_clr %b ent_clr %b expected 0 1 0 0", st, op_sub, all_clr, ent_clr); end
    checks++; if ((n_alu_go - b_go) + (n_dig_ld - b_ld) !== 0) begin errors++; $display("FAIL clear_no_strobe: got %0d expected 0", (n_alu_go - b_go) + (n_dig_ld - b_ld)); end
  endtask

  task automatic test_mem();
    int b_rd, b_wr;
    do_reset();
    b_rd = n_mem_rd; b_wr = n_mem_wr;
    press(4'hE);
    checks++; if ({st, ent_clr, mem_rd} !== {3'd0, 1'b0, 1'b0}) begin errors++; $display("FAIL mem_e_empty: st %0d ent_clr %b mem_rd %b expected 0 0 0", st, ent_clr, mem_rd); end
    press(4'd8);
    press(4'hF);
    checks++; if ({st, mem_wr} !== {3'd1, MEM}) begin errors++; $display("FAIL mem_setm: st %0d mem_wr %b expected 1 %b", st, mem_wr, MEM); end
    press(4'hC);
    press(4'hE);
    checks++; if ({st, mem_rd, ent_clr} !== (MEM ? {3'd3, 2'b11} : {3'd2, 2'b00})) begin errors++; $display("FAIL mem_getm: st %0d mem_rd %b ent_clr %b", st, mem_rd, ent_clr); end
    press(4'd6);
    checks++; if ({st, dig_ovf, dig_ld} !== (MEM ? {3'd3, 2'b10} : {3'd3, 2'b01})) begin errors++; $display("FAIL mem_next_digit: st %0d dig_ovf %b dig_ld %b", st, dig_ovf, dig_ld); end
    checks++; if (n_mem_rd - b_rd !== (MEM ? 1 : 0)) begin errors++; $display("FAIL mem_rd_count: got %0d expected %0d", n_mem_rd - b_rd, MEM ? 1 : 0); end
    checks++; if (n_mem_wr - b_wr !== (MEM ? 1 : 0)) begin errors++; $display("FAIL mem_wr_count: got %0d expected %0d", n_mem_wr - b_wr, MEM ? 1 : 0); end
  endtask

  task automatic test_reset_in_wait();
    do_reset();
    press(4'd1);
    press(4'hC);
    press(4'd2);
    press(4'hD);
    checks++; if (st !== 3'd5) begin errors++; $display("FAIL rwait_enter: got st %0d expected 5", st); end
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    pulse_done();
    checks++; if ({st, key_rdy} !== {3'd0, 1'b1}) begin errors++; $display("FAIL rwait_after_done: st %0d key_rdy %b expected 0 1", st, key_rdy); end
    pulse_done();
    checks++; if (st !== 3'd0) begin errors++; $display("FAIL rwait_stays: got st %0d expected 0", st); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_chain();
    test_clear();
    test_mem();
    test_reset_in_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
